ripple_seq_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit additions on the team's existing 4-bit `ripple` adder (ports a, b, cin, sum, cout). It processes one nibble per clock and carries between cycles through a registered carry. Operands enter and results leave over valid/ready handshakes. It sits between an operand producer and a result consumer, so wide adds need only one 4-bit adder instance.

---
 rtl/ripple_seq_pkg.sv | 20 ++
 rtl/ripple_seq_ctrl_if.sv | 41 ++++
 rtl/ripple_seq_ctrl_ripple.sv | 23 ++
 rtl/ripple_seq_ctrl.sv | 115 +++++++++++
 tb/tb_ripple_seq_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ripple_seq_pkg.sv
// ripple_seq_pkg
// Shared types and constants for the nibble-serial adder sequencer:
//   state_t      - sequencer state encoding (IDLE, RUN, DONE)
//   SLICE_W      - width of the single adder slice
//   calc_nslice  - number of slice cycles needed for a given operand width
package ripple_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/ripple_seq_ctrl_if.sv
// ripple_seq_ctrl_if
// Operand/result handshake bundle for ripple_seq_ctrl.
//   in_valid/in_ready, a, b, cin (and sub when RIPPLE_SEQ_SUB_EN) : operand side
//   out_valid/out_ready, sum, cout                               : result side
//   busy                                                         : sequencer occupied
// Modports: slave = sequencer side, master = producer/consumer side.
interface ripple_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef RIPPLE_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin,
`ifdef RIPPLE_SEQ_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin,
`ifdef RIPPLE_SEQ_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/ripple_seq_ctrl_ripple.sv
// ripple
// Existing 4-bit ripple-carry adder used as the single slice of the sequencer.
//   a, b : 4-bit addends   cin  : carry in
//   sum  : 4-bit result    cout : carry out of bit 3
module ripple (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic w_c;

  always_comb begin
    w_c = cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end
endmodule

// File: rtl/ripple_seq_ctrl.sv
// ripple_seq_ctrl
// Performs WIDTH-bit additions one nibble per clock on a single 4-bit ripple
// adder, carrying between cycles through a registered carry.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : ripple_seq_ctrl_if.slave (operand and result handshakes, busy)
// Optional build macro RIPPLE_SEQ_SUB_EN adds the bus.sub input: when set at
// acceptance the operation becomes a - b (cout=1 means no borrow).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble added per cycle, idx counts 0..NSLICE-1
// DONE  | result held with out_valid high until out_ready
module ripple_seq_ctrl
  import ripple_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  ripple_seq_ctrl_if.slave bus
);
  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic               r_carry, r_cout;
  logic [IDXW-1:0]    r_idx;
  logic               w_in_ready, w_out_valid, w_busy, w_accept, w_last;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_carry_load;
  logic [SLICE_W-1:0] w_a_nib, w_b_nib, w_sum_nib;
  logic               w_cout_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by rst_n so no handshake can complete while reset is held.
        w_in_ready = rst_n;
        if (bus.in_valid && rst_n) w_state_nxt = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_in_ready && bus.in_valid;
  assign w_last   = (r_idx == LAST_IDX);

`ifdef RIPPLE_SEQ_SUB_EN
  // Subtraction as a + ~b + 1; cin is ignored in that mode.
  assign w_b_load     = bus.sub ? ~bus.b : bus.b;
  assign w_carry_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b_load     = bus.b;
  assign w_carry_load = bus.cin;
`endif

  assign w_a_nib = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_b_nib = r_b[int'(r_idx)*SLICE_W +: SLICE_W];

  ripple u_ripple (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_sum_nib),
    .cout (w_cout_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= w_b_load;
      r_carry <= w_carry_load;
      r_sum   <= '0;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[int'(r_idx)*SLICE_W +: SLICE_W] <= w_sum_nib;
      r_carry <= w_cout_nib;
      r_idx   <= r_idx + 1'b1;
      if (w_last) r_cout <= w_cout_nib;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
endmodule

// File: tb/tb_ripple_seq_ctrl.sv
module tb_ripple_seq_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ripple_seq_ctrl_if #(.WIDTH(W)) bus ();

  ripple_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Drives one operation through both handshakes. Returns the result seen at
  // out_valid, the cycle count from the accepting edge to out_valid, and a
  // count of protocol anomalies (in_ready/busy/out_valid/stability).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub, input int hold,
                        input logic early, output logic [W-1:0] osum,
                        output logic ocout, output int lat, output int bad);
    bus.a = ia; bus.b = ib; bus.cin = icin;
`ifdef RIPPLE_SEQ_SUB_EN
    bus.sub = isub;
`else
    if (isub) $display("note: sub requested without RIPPLE_SEQ_SUB_EN");
`endif
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
`ifdef RIPPLE_SEQ_SUB_EN
    bus.sub = 1'($urandom);
`endif
    if (early) bus.out_ready = 1'b1;
    lat = 0; bad = 0; osum = 'x; ocout = 1'bx;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) return;
    osum = bus.sum; ocout = bus.cout;
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.sum !== osum || bus.cout !== ocout ||
          bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) bad++;
  endtask

  task automatic test_reset;
    #2;
    bus.in_valid = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL rst_sum: got %h expected 0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL rst_cout: got %b expected 0", bus.cout); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_ignore: got %b expected 0", bus.busy); end
    bus.in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed;
    logic [W-1:0] va[4] = '{16'h0000, 16'h00FF, 16'hFFFF, 16'hA5A5};
    logic [W-1:0] vb[4] = '{16'h0000, 16'h0001, 16'h0001, 16'h5A5A};
    logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[4] = '{16'h0000, 16'h0100, 16'h0000, 16'h0000};
    logic         ec[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] s; logic c; int lat, bad;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, 0, 1'b0, s, c, lat, bad);
      checks++; if (s !== es[i]) begin errors++; $display("FAIL dir%0d_sum: got %h expected %h", i, s, es[i]); end
      checks++; if (c !== ec[i]) begin errors++; $display("FAIL dir%0d_cout: got %b expected %b", i, c, ec[i]); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL dir%0d_protocol: got %0d anomalies expected 0", i, bad); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] s; logic c; int lat, bad;
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 3, 1'b0, s, c, lat, bad);
    checks++; if (s !== 16'h2345) begin errors++; $display("FAIL bp_sum: got %h expected 2345", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL bp_cout: got %b expected 0", c); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_protocol: got %0d anomalies expected 0", bad); end
  endtask

  task automatic test_reset_midop;
    logic [W-1:0] s; logic c; int lat, bad;
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1;
`ifdef RIPPLE_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL abort_sum: got %h expected 0000", bus.sum); end
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.cout !== 1'b0)
      begin errors++; $display("FAIL abort_flags: got busy=%b ov=%b ir=%b co=%b expected all 0", bus.busy, bus.out_valid, bus.in_ready, bus.cout); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, 1'b0, s, c, lat, bad);
    checks++; if (s !== 16'h0007 || c !== 1'b0) begin errors++; $display("FAIL post_abort: got %h/%b expected 0007/0", s, c); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_abort_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_back_to_back;
    int first = -1, second = -1, pulses_ok = 0, pulses = 0, n = 0;
    bus.a = 16'h0F0F; bus.b = 16'h0101; bus.cin = 1'b1;
`ifdef RIPPLE_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        pulses++;
        if (bus.sum === 16'h1011 && bus.cout === 1'b0) pulses_ok++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    bus.in_valid = 1'b0;
    while (bus.busy !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    bus.out_ready = 1'b0;
    checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first: got cycle %0d expected 4", first); end
    checks++; if (second - first !== 6) begin errors++; $display("FAIL b2b_period: got %0d expected 6", second - first); end
    checks++; if (pulses !== 3 || pulses_ok !== pulses) begin errors++; $display("FAIL b2b_results: got %0d/%0d good pulses expected 3/3", pulses_ok, pulses); end
    checks++; if (n >= 20) begin errors++; $display("FAIL b2b_drain: got %0d cycles expected < 20", n); end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb, s, es; logic rc, rs, c, ec, early; int hold, lat, bad;
    logic [W:0] wide;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef RIPPLE_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 8 == 0) rb = ~ra;
      early = 1'($urandom);
      hold  = early ? 0 : int'($urandom_range(0, 2));
      if (rs) begin
        es = ra - rb;
        ec = (ra >= rb);
      end else begin
        wide = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
        es = wide[W-1:0];
        ec = wide[W];
      end
      run_op(ra, rb, rc, rs, hold, early, s, c, lat, bad);
      checks++; if (s !== es || c !== ec) begin errors++; $display("FAIL rnd%0d_result: got %h/%b expected %h/%b (a=%h b=%h cin=%b sub=%b)", i, s, c, es, ec, ra, rb, rc, rs); end
      checks++; if (lat !== 4 || bad !== 0) begin errors++; $display("FAIL rnd%0d_timing: got lat=%0d anomalies=%0d expected 4/0", i, lat, bad); end
    end
  endtask

`ifdef RIPPLE_SEQ_SUB_EN
  task automatic test_sub;
    logic [W-1:0] s; logic c; int lat, bad;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, s, c, lat, bad);
    checks++; if (s !== 16'hFFFE || c !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %h/%b expected fffe/0", s, c); end
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0, s, c, lat, bad);
    checks++; if (s !== 16'h0002 || c !== 1'b1) begin errors++; $display("FAIL sub_noborrow: got %h/%b expected 0002/1", s, c); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef RIPPLE_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_midop;
    test_back_to_back;
    test_random;
`ifdef RIPPLE_SEQ_SUB_EN
    test_sub;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
